// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide sequencer:
// funct3 op codes, FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

   localparam int unsigned MD_XLEN = 64;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_CALC,
      ST_FIN,
      ST_DONE
   } state_e;

   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic a_is_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_sdiv(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply / restoring divide for RV64M, one op at a time.
// Multiply and divide share the counter and the 2*XLEN shift register.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = MD_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN      = {1'b1, {(XLEN-1){1'b0}}};

   state_e            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2*XLEN-1:0] sreg_q, sreg_d;
   logic              negq_q, negq_d;
   logic              negr_q, negr_d;

   logic              sa, sb;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, div_ovf;
   logic [XLEN:0]     shifted, trial, mul_sum;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s;

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

   always_comb begin
      sa       = a_is_signed(op_q) & a_q[XLEN-1];
      sb       = b_is_signed(op_q) & b_q[XLEN-1];
      a_mag    = sa ? -a_q : a_q;
      b_mag    = sb ? -b_q : b_q;
      div_zero = op_is_div(op_q) && (b_q == '0);
      div_ovf  = op_is_sdiv(op_q) && (a_q == MIN) && (b_q == '1);
      // Divide: sreg holds {remainder, dividend/quotient}; shift one bit in and trial-subtract.
      shifted  = sreg_q[2*XLEN-1:XLEN-1];
      trial    = shifted - {1'b0, opnd_q};
      mul_sum  = {1'b0, sreg_q[2*XLEN-1:XLEN]} + (sreg_q[0] ? {1'b0, opnd_q} : '0);
      prod_s   = negq_q ? -sreg_q : sreg_q;
      quo_s    = negq_q ? -sreg_q[XLEN-1:0] : sreg_q[XLEN-1:0];
      rem_s    = negr_q ? -sreg_q[2*XLEN-1:XLEN] : sreg_q[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      opnd_d   = opnd_q;
      sreg_d   = sreg_q;
      negq_d   = negq_q;
      negr_d   = negr_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !kill) begin
               op_d    = op;
               a_d     = a;
               b_d     = b;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            negq_d = sa ^ sb;
            negr_d = sa;
            cnt_d  = '0;
            if (op_is_div(op_q)) begin
               opnd_d = b_mag;
               sreg_d = {{XLEN{1'b0}}, a_mag};
            end else begin
               opnd_d = a_mag;
               sreg_d = {{XLEN{1'b0}}, b_mag};
            end
            if (div_zero) begin
               result_d = op_q[1] ? a_q : '1;
               state_d  = ST_DONE;
            end else if (div_ovf) begin
               result_d = op_q[1] ? '0 : MIN;
               state_d  = ST_DONE;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (op_is_div(op_q)) begin
               if (trial[XLEN])
                  sreg_d = {shifted[XLEN-1:0], sreg_q[XLEN-2:0], 1'b0};
               else
                  sreg_d = {trial[XLEN-1:0], sreg_q[XLEN-2:0], 1'b1};
            end else begin
               sreg_d = {mul_sum, sreg_q[XLEN-1:1]};
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_FIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FIN: begin
            case (op_q)
               OP_MUL:                        result_d = prod_s[XLEN-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_s[2*XLEN-1:XLEN];
               OP_DIV, OP_DIVU:               result_d = quo_s;
               default:                       result_d = rem_s;
            endcase
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A flush wins over everything, including a fast-path result write.
      if (kill) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   always_comb begin
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         opnd_q   <= '0;
         sreg_q   <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         opnd_q   <= opnd_d;
         sreg_q   <= sreg_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus scoreboard keyed on done,
// with hand sequences for timing, kill, ignored start and mid-op reset.
module tb_muldiv_seq;

   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam int LAT_N = 67;
   localparam int LAT_F = 2;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  op;
   logic [63:0] a, b;
   logic        busy, done;
   logic [63:0] result;

   typedef struct {
      logic [63:0] res;
      int          exp_cyc;
      int          id;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        tbl[$];
   int          cyc = 0;
   int          nvec = 0;
   int          errs = 0;
   logic [63:0] last_exp = '0;

   muldiv_seq #(.XLEN(64)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .kill   (kill),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (done === 1'b1) begin
         nvec++;
         if (sb.size() == 0) begin
            errs++;
            $display("FAIL spurious_done cycle=%0d result=%h required=no done", cyc, result);
         end else begin
            mon_e    = sb.pop_front();
            last_exp = mon_e.res;
            if (result !== mon_e.res || cyc != mon_e.exp_cyc)
            begin
               errs++;
               $display("FAIL vec%0d result=%h cycle=%0d required result=%h cycle=%0d",
                        mon_e.id, result, cyc, mon_e.res, mon_e.exp_cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [127:0]       p;
      logic signed [63:0] sx, sy;
      sx = x;
      sy = y;
      case (o)
         3'd0: begin p = {64'd0, x} * {64'd0, y}; return p[63:0]; end
         3'd1: begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; return p[127:64]; end
         3'd2: begin p = {{64{x[63]}}, x} * {64'd0, y}; return p[127:64]; end
         3'd3: begin p = {64'd0, x} * {64'd0, y}; return p[127:64]; end
         3'd4: begin
            if (y == 0) return ONES;
            if (x == MINV && y == ONES) return MINV;
            return sx / sy;
         end
         3'd5: return (y == 0) ? ONES : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == MINV && y == ONES) return 64'd0;
            return sx % sy;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
      if (o[2] && y == 0) return LAT_F;
      if ((o == 3'd4 || o == 3'd6) && x == MINV && y == ONES) return LAT_F;
      return LAT_N;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic wait_sb(input string nm);
      int budget = 0;
      while (sb.size() != 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (sb.size() != 0) begin
         nvec++;
         errs++;
         $display("FAIL %s timeout pending=%0d required=0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (busy !== 1'b0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] e, input int lat, input int id);
      @(negedge clk);
      wait_idle();
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      sb.push_back('{e, cyc + lat, id});
      @(negedge clk);
      start = 1'b0;
      wait_sb($sformatf("vec%0d", id));
   endtask

   initial begin
      int n0;
      logic [2:0]  ro;
      logic [63:0] ra, rb;

      rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy",   64'(busy),   64'd0);
      chk("reset_done",   64'(done),   64'd0);
      chk("reset_result", result,      64'd0);
      rst = 1'b0;

      // MUL 7 * -3 accepted in cycle 10: busy from 11, done only at 77, idle at 78.
      while (cyc < 10) @(negedge clk);
      chk("mul_busy_c10", 64'(busy), 64'd0);
      start = 1'b1; op = 3'd0; a = 64'd7; b = 64'hFFFF_FFFF_FFFF_FFFD;
      sb.push_back('{64'hFFFF_FFFF_FFFF_FFEB, 77, 0});
      @(negedge clk);
      start = 1'b0;
      chk("mul_busy_c11", 64'(busy), 64'd1);
      while (cyc < 78) @(negedge clk);
      chk("mul_busy_c78", 64'(busy), 64'd0);
      chk("mul_done_seen", 64'(sb.size()), 64'd0);
      sb.delete();

      tbl.push_back('{3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, LAT_N});
      tbl.push_back('{3'd1, ONES, ONES, 64'd0, LAT_N});
      tbl.push_back('{3'd4, 64'd100, 64'd0, ONES, LAT_F});
      tbl.push_back('{3'd7, 64'd100, 64'd0, 64'd100, LAT_F});
      tbl.push_back('{3'd5, 64'd100, 64'd0, ONES, LAT_F});
      tbl.push_back('{3'd6, 64'd100, 64'd0, 64'd100, LAT_F});
      tbl.push_back('{3'd4, MINV, ONES, MINV, LAT_F});
      tbl.push_back('{3'd6, MINV, ONES, 64'd0, LAT_F});
      tbl.push_back('{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, LAT_N});
      tbl.push_back('{3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_N});
      tbl.push_back('{3'd5, 64'd20, 64'd3, 64'd6, LAT_N});
      tbl.push_back('{3'd7, 64'd20, 64'd3, 64'd2, LAT_N});
      tbl.push_back('{3'd2, ONES, 64'd2, ONES, LAT_N});
      tbl.push_back('{3'd0, 64'h1234_5678, 64'h10, 64'h1_2345_6780, LAT_N});
      tbl.push_back('{3'd5, MINV, ONES, 64'd0, LAT_N});
      tbl.push_back('{3'd7, MINV, ONES, MINV, LAT_N});
      tbl.push_back('{3'd4, ONES, ONES, 64'd1, LAT_N});
      tbl.push_back('{3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, LAT_N});
      tbl.push_back('{3'd6, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, LAT_N});
      for (int i = 0; i < tbl.size(); i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, i + 1);

      for (int i = 0; i < 12; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: begin
               rb = 64'($urandom_range(1, 20));
               if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            1: rb = 64'd0;
            default: rb = {$urandom, $urandom};
         endcase
         run_op(ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb), 100 + i);
      end

      // Kill mid-divide: no done, idle next cycle, result holds.
      @(negedge clk);
      wait_idle();
      start = 1'b1; op = 3'd5; a = 64'd20; b = 64'd3;
      n0 = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < n0 + 30) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_busy",   64'(busy), 64'd0);
      chk("kill_done",   64'(done), 64'd0);
      chk("kill_result", result,    last_exp);
      repeat (80) @(negedge clk);

      // Kill together with start is not an accept.
      start = 1'b1; kill = 1'b1; op = 3'd0; a = 64'd3; b = 64'd3;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("kill_start_busy", 64'(busy), 64'd0);

      // Kill during PREP of a fast-path op suppresses its result.
      start = 1'b1; op = 3'd4; a = 64'd100; b = 64'd0;
      @(negedge clk);
      start = 1'b0; kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill_prep_busy",   64'(busy), 64'd0);
      chk("kill_prep_result", result,    last_exp);
      repeat (5) @(negedge clk);

      // Restart DIVU 20/3; a start pulsed while busy must be ignored.
      start = 1'b1; op = 3'd5; a = 64'd20; b = 64'd3;
      sb.push_back('{64'd6, cyc + LAT_N, 200});
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; op = 3'd0; a = 64'd1; b = 64'd1;
      @(negedge clk);
      start = 1'b0;
      wait_sb("restart_divu");
      repeat (80) @(negedge clk);
      chk("ignored_start_idle", 64'(busy), 64'd0);

      // Reset mid-operation clears everything and emits no done.
      start = 1'b1; op = 3'd4; a = 64'hFFFF_FFFF_FFFF_FFF9; b = 64'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_exp = '0;
      chk("midrst_busy",   64'(busy), 64'd0);
      chk("midrst_done",   64'(done), 64'd0);
      chk("midrst_result", result,    64'd0);
      repeat (80) @(negedge clk);

      run_op(3'd0, 64'd6, 64'd7, 64'd42, LAT_N, 300);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
